// File: rtl/time_set_sequencer.sv
// time_set_sequencer: debounced buttons, RUN/SET sequencing,
// field select, inc/dec strobes with auto-repeat, blink control.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   btn_mode/item/up/down  raw async buttons, active-high
//   run_en, set_mode  RUN / SET state indication
//   view_dmy          0 = ss/mm/hh page, 1 = dd/mo/yyyy page
//   item_sel[2:0]     field under adjustment (0..5)
//   inc_pulse/dec_pulse  one-cycle adjust strobes for item_sel
//   blink_on          blank the selected field
//
// Optional: define SET_TIMEOUT_EN to leave SET after
// TIMEOUT_CYC cycles of inactivity.
module time_set_sequencer #(
  parameter int unsigned DEBOUNCE_CYC     = 1_000_000,
  parameter int unsigned REPEAT_DELAY_CYC = 25_000_000,
  parameter int unsigned REPEAT_RATE_CYC  = 5_000_000,
  parameter int unsigned BLINK_HALF_CYC   = 12_500_000,
  parameter int unsigned TIMEOUT_CYC      = 500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_item,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       run_en,
  output logic       set_mode,
  output logic       view_dmy,
  output logic [2:0] item_sel,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic       blink_on
);

  localparam int unsigned RP_MAX =
    (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ?
    REPEAT_DELAY_CYC : REPEAT_RATE_CYC;

  localparam int DBW = $clog2(DEBOUNCE_CYC + 1);
  localparam int RPW = $clog2(RP_MAX + 1);
  localparam int BKW = $clog2(BLINK_HALF_CYC + 1);

  localparam logic [DBW-1:0] DB_LAST =
    DBW'(DEBOUNCE_CYC - 1);
  localparam logic [RPW-1:0] RP_DELAY =
    RPW'(REPEAT_DELAY_CYC - 1);
  localparam logic [RPW-1:0] RP_RATE =
    RPW'(REPEAT_RATE_CYC - 1);
  localparam logic [BKW-1:0] BK_LAST =
    BKW'(BLINK_HALF_CYC - 1);

  typedef enum logic {
    S_RUN = 1'b0,
    S_SET = 1'b1
  } state_t;

  // Button bit order: 0 mode, 1 item, 2 up, 3 down.
  logic [3:0]     raw;
  logic [3:0]     sync1;
  logic [3:0]     sync2;
  logic [3:0]     db;
  logic [3:0]     db_q;
  logic [3:0]     press;
  logic [DBW-1:0] db_cnt [4];

  assign raw = {btn_down, btn_up, btn_item, btn_mode};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      db_q  <= db;
      for (int i = 0; i < 4; i++) begin
        // Any cycle that agrees with the accepted level
        // restarts the stability count.
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  assign press = db & ~db_q;

  logic ev_mode;
  logic ev_item;
  logic ev_up;
  logic ev_dn;
  logic db_up;
  logic db_dn;
  logic up_only;
  logic dn_only;
  logic both_held;
  logic any_held;

  assign ev_mode   = press[0];
  assign ev_item   = press[1];
  assign ev_up     = press[2];
  assign ev_dn     = press[3];
  assign db_up     = db[2];
  assign db_dn     = db[3];
  assign up_only   = db_up & ~db_dn;
  assign dn_only   = db_dn & ~db_up;
  assign both_held = db_up & db_dn;
  assign any_held  = db_up | db_dn;

  state_t         state;
  state_t         state_n;
  logic [2:0]     item_n;
  logic           view_n;
  logic           inc_n;
  logic           dec_n;
  logic           blink_n;

  // Auto-repeat: armed only by a press taken in SET.
  logic           armed;
  logic           armed_n;
  logic           rpt_dn;
  logic           dir_n;
  logic           rpt_first;
  logic           first_n;
  logic [RPW-1:0] rpt_cnt;
  logic [RPW-1:0] rpt_n;
  logic [RPW-1:0] rpt_lim;

  logic [BKW-1:0] bcnt;
  logic [BKW-1:0] bcnt_n;
  logic           blink_ph;
  logic           ph_n;

  logic           leave;

`ifdef SET_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_CYC);

  logic [TOW-1:0] to_cnt;
  logic [TOW-1:0] to_n;
  logic           to_hit;

  assign to_hit = (to_cnt == TO_LAST);
  assign leave  = ev_mode | to_hit;
`else
  assign leave  = ev_mode;
`endif

  assign rpt_lim = rpt_first ? RP_DELAY : RP_RATE;

  always_comb begin
    state_n = state;
    item_n  = item_sel;
    view_n  = view_dmy;
    inc_n   = 1'b0;
    dec_n   = 1'b0;
    armed_n = armed;
    dir_n   = rpt_dn;
    first_n = rpt_first;
    rpt_n   = rpt_cnt;
    bcnt_n  = bcnt;
    ph_n    = blink_ph;
`ifdef SET_TIMEOUT_EN
    to_n    = to_cnt;
`endif
    unique case (state)
      S_RUN: begin
        armed_n = 1'b0;
        rpt_n   = '0;
        bcnt_n  = '0;
        ph_n    = 1'b0;
`ifdef SET_TIMEOUT_EN
        to_n    = '0;
`endif
        if (ev_mode) begin
          state_n = S_SET;
          item_n  = view_dmy ? 3'd3 : 3'd0;
        end else if (ev_item) begin
          view_n = ~view_dmy;
        end
      end
      S_SET: begin
        if (bcnt == BK_LAST) begin
          bcnt_n = '0;
          ph_n   = ~blink_ph;
        end else begin
          bcnt_n = bcnt + BKW'(1);
        end

        // Losing the single-button hold drops the repeat;
        // only a fresh press can re-arm it.
        if (armed) begin
          if (both_held ||
              !(rpt_dn ? dn_only : up_only)) begin
            armed_n = 1'b0;
            rpt_n   = '0;
          end else if (rpt_cnt == rpt_lim) begin
            inc_n   = ~rpt_dn;
            dec_n   = rpt_dn;
            rpt_n   = '0;
            first_n = 1'b0;
          end else begin
            rpt_n = rpt_cnt + RPW'(1);
          end
        end else begin
          rpt_n = '0;
        end

`ifdef SET_TIMEOUT_EN
        if ((|press) || any_held) begin
          to_n = '0;
        end else if (!to_hit) begin
          to_n = to_cnt + TOW'(1);
        end
`endif

        if (leave) begin
          state_n = S_RUN;
          inc_n   = 1'b0;
          dec_n   = 1'b0;
          armed_n = 1'b0;
          rpt_n   = '0;
        end else if (ev_item) begin
          item_n  = (item_sel == 3'd5) ?
                    3'd0 : item_sel + 3'd1;
          view_n  = (item_n >= 3'd3);
          bcnt_n  = '0;
          ph_n    = 1'b0;
          inc_n   = 1'b0;
          dec_n   = 1'b0;
        end else if (ev_up && !db_dn) begin
          inc_n   = 1'b1;
          dec_n   = 1'b0;
          armed_n = 1'b1;
          dir_n   = 1'b0;
          first_n = 1'b1;
          rpt_n   = '0;
        end else if (ev_dn && !db_up) begin
          inc_n   = 1'b0;
          dec_n   = 1'b1;
          armed_n = 1'b1;
          dir_n   = 1'b1;
          first_n = 1'b1;
          rpt_n   = '0;
        end
      end
    endcase
  end

  assign blink_n = (state_n == S_SET) & ph_n & ~any_held;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RUN;
      item_sel  <= '0;
      view_dmy  <= 1'b0;
      inc_pulse <= 1'b0;
      dec_pulse <= 1'b0;
      blink_on  <= 1'b0;
      armed     <= 1'b0;
      rpt_dn    <= 1'b0;
      rpt_first <= 1'b0;
      rpt_cnt   <= '0;
      bcnt      <= '0;
      blink_ph  <= 1'b0;
`ifdef SET_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      state     <= state_n;
      item_sel  <= item_n;
      view_dmy  <= view_n;
      inc_pulse <= inc_n;
      dec_pulse <= dec_n;
      blink_on  <= blink_n;
      armed     <= armed_n;
      rpt_dn    <= dir_n;
      rpt_first <= first_n;
      rpt_cnt   <= rpt_n;
      bcnt      <= bcnt_n;
      blink_ph  <= ph_n;
`ifdef SET_TIMEOUT_EN
      to_cnt    <= to_n;
`endif
    end
  end

  assign set_mode = (state == S_SET);
  assign run_en   = (state == S_RUN);

endmodule

// File: tb/tb_time_set_sequencer.sv
// tb_time_set_sequencer: directed scoreboard bench for
// time_set_sequencer with small timing parameters.
module tb_time_set_sequencer;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RR = 5;
  localparam int BH = 8;
  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_item = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       run_en;
  logic       set_mode;
  logic       view_dmy;
  logic [2:0] item_sel;
  logic       inc_pulse;
  logic       dec_pulse;
  logic       blink_on;

  time_set_sequencer #(
    .DEBOUNCE_CYC(DB),
    .REPEAT_DELAY_CYC(RD),
    .REPEAT_RATE_CYC(RR),
    .BLINK_HALF_CYC(BH),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_mode(btn_mode),
    .btn_item(btn_item),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .run_en(run_en),
    .set_mode(set_mode),
    .view_dmy(view_dmy),
    .item_sel(item_sel),
    .inc_pulse(inc_pulse),
    .dec_pulse(dec_pulse),
    .blink_on(blink_on)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic       r;
    logic       s;
    logic       v;
    logic [2:0] it;
    logic       b;
  } lvl_t;

  typedef struct {
    int         at;
    logic       i;
    logic       d;
    logic [2:0] it;
  } pls_t;

  lvl_t lq[$];
  pls_t pq[$];

  int   n_tests = 0;
  int   n_fail = 0;
  logic done = 1'b0;
  logic flushed = 1'b0;

  task automatic lvl(input int at, input logic r,
                     input logic s, input logic v,
                     input logic [2:0] it, input logic b);
    lvl_t x;
    int   k;
    x.at = at; x.r = r; x.s = s;
    x.v = v; x.it = it; x.b = b;
    k = 0;
    while (k < lq.size() && lq[k].at <= at) k++;
    lq.insert(k, x);
  endtask

  task automatic pls(input int at, input logic i,
                     input logic d, input logic [2:0] it);
    pls_t x;
    int   k;
    x.at = at; x.i = i; x.d = d; x.it = it;
    k = 0;
    while (k < pq.size() && pq[k].at <= at) k++;
    pq.insert(k, x);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: level checks fire at their scheduled cycle,
  // pulse records are consumed whenever a strobe appears.
  always @(negedge clk) begin
    lvl_t l;
    pls_t p;
    while (lq.size() > 0 && lq[0].at <= cyc) begin
      l = lq.pop_front();
      n_tests++;
      if (l.at != cyc || run_en !== l.r ||
          set_mode !== l.s || view_dmy !== l.v ||
          item_sel !== l.it || blink_on !== l.b) begin
        n_fail++;
        $display({"FAIL lvl@%0d (cyc %0d): got run=%b ",
                  "set=%b view=%b item=%0d blink=%b, want ",
                  "run=%b set=%b view=%b item=%0d blink=%b"},
                 l.at, cyc, run_en, set_mode, view_dmy,
                 item_sel, blink_on, l.r, l.s, l.v, l.it,
                 l.b);
      end
    end
    while (pq.size() > 0 && pq[0].at < cyc) begin
      p = pq.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL pulse_missing@%0d: got none, want inc=%b dec=%b",
               p.at, p.i, p.d);
    end
    if (inc_pulse === 1'b1 || dec_pulse === 1'b1) begin
      n_tests++;
      if (pq.size() == 0 || pq[0].at != cyc) begin
        n_fail++;
        $display("FAIL pulse_unexpected@%0d: got inc=%b dec=%b item=%0d, want none",
                 cyc, inc_pulse, dec_pulse, item_sel);
      end else begin
        p = pq.pop_front();
        if (inc_pulse !== p.i || dec_pulse !== p.d ||
            item_sel !== p.it) begin
          n_fail++;
          $display("FAIL pulse@%0d: got inc=%b dec=%b item=%0d, want inc=%b dec=%b item=%0d",
                   cyc, inc_pulse, dec_pulse, item_sel,
                   p.i, p.d, p.it);
        end
      end
    end
    if (done && !flushed) begin
      flushed <= 1'b1;
      n_tests++;
      if (lq.size() + pq.size() != 0) begin
        n_fail++;
        $display("FAIL leftover: got %0d unchecked records, want 0",
                 lq.size() + pq.size());
      end
    end
  end

  initial begin
    int t, s, t1, t2, t3, tu, td, ta, tr, tq, tm, s3;

    // Reset values, during and after reset
    idle(2);
    lvl(cyc + 1, 1, 0, 0, 3'd0, 0);
    idle(1);
    rst = 1'b0;
    lvl(cyc + 2, 1, 0, 0, 3'd0, 0);
    idle(3);

    // RUN: item toggles view_dmy, 7 cycles after raw edge
    t = cyc;
    btn_item = 1'b1;
    lvl(t + 6, 1, 0, 0, 3'd0, 0);
    lvl(t + 7, 1, 0, 1, 3'd0, 0);
    idle(10);
    btn_item = 1'b0;
    idle(10);
    t = cyc;
    btn_item = 1'b1;
    lvl(t + 6, 1, 0, 1, 3'd0, 0);
    lvl(t + 7, 1, 0, 0, 3'd0, 0);
    idle(10);
    btn_item = 1'b0;
    idle(10);

    // 3-cycle glitch is rejected
    t = cyc;
    btn_item = 1'b1;
    idle(3);
    btn_item = 1'b0;
    lvl(t + 8, 1, 0, 0, 3'd0, 0);
    lvl(t + 12, 1, 0, 0, 3'd0, 0);
    idle(12);

    // view_dmy=1, then mode -> SET with item 3
    t = cyc;
    btn_item = 1'b1;
    lvl(t + 7, 1, 0, 1, 3'd0, 0);
    idle(10);
    btn_item = 1'b0;
    idle(10);
    t = cyc;
    btn_mode = 1'b1;
    s = t + 7;
    lvl(s - 1, 1, 0, 1, 3'd0, 0);
    lvl(s, 0, 1, 1, 3'd3, 0);
    lvl(s + 7, 0, 1, 1, 3'd3, 0);
    lvl(s + 8, 0, 1, 1, 3'd3, 1);
    lvl(s + 15, 0, 1, 1, 3'd3, 1);
    lvl(s + 16, 0, 1, 1, 3'd3, 0);
    idle(10);
    btn_mode = 1'b0;

    // Item presses 3 -> 4 -> 5 -> 0, blink restarts
    wait_until(s + 17);
    t1 = cyc;
    btn_item = 1'b1;
    lvl(t1 + 6, 0, 1, 1, 3'd3, 0);
    lvl(t1 + 7, 0, 1, 1, 3'd4, 0);
    idle(10);
    btn_item = 1'b0;
    wait_until(t1 + 20);
    t2 = cyc;
    btn_item = 1'b1;
    lvl(t2 + 7, 0, 1, 1, 3'd5, 0);
    idle(10);
    btn_item = 1'b0;
    wait_until(t2 + 20);
    t3 = cyc;
    btn_item = 1'b1;
    lvl(t3 + 7, 0, 1, 0, 3'd0, 0);
    lvl(t3 + 14, 0, 1, 0, 3'd0, 0);
    lvl(t3 + 15, 0, 1, 0, 3'd0, 1);
    lvl(t3 + 23, 0, 1, 0, 3'd0, 0);
    idle(10);
    btn_item = 1'b0;
    wait_until(t3 + 24);

    // Up hold: press pulse then auto-repeat, blink forced off
    tu = cyc;
    btn_up = 1'b1;
    pls(tu + 7, 1, 0, 3'd0);
    pls(tu + 27, 1, 0, 3'd0);
    pls(tu + 32, 1, 0, 3'd0);
    pls(tu + 37, 1, 0, 3'd0);
    pls(tu + 42, 1, 0, 3'd0);
    lvl(tu + 10, 0, 1, 0, 3'd0, 0);
    lvl(tu + 20, 0, 1, 0, 3'd0, 0);
    lvl(tu + 30, 0, 1, 0, 3'd0, 0);
    lvl(tu + 40, 0, 1, 0, 3'd0, 0);
    idle(38);
    btn_up = 1'b0;
    idle(12);

    // Down press: single dec pulse
    td = cyc;
    btn_down = 1'b1;
    pls(td + 7, 0, 1, 3'd0);
    idle(10);
    btn_down = 1'b0;
    idle(10);

    // Up then down: repeat cancelled, no pulse on release
    ta = cyc;
    btn_up = 1'b1;
    pls(ta + 7, 1, 0, 3'd0);
    idle(10);
    btn_down = 1'b1;
    lvl(ta + 20, 0, 1, 0, 3'd0, 0);
    idle(20);
    btn_down = 1'b0;
    idle(30);
    btn_up = 1'b0;
    idle(10);

    // Reset during repeat; item held across reset release
    tr = cyc;
    btn_up = 1'b1;
    pls(tr + 7, 1, 0, 3'd0);
    pls(tr + 27, 1, 0, 3'd0);
    wait_until(tr + 30);
    rst = 1'b1;
    btn_item = 1'b1;
    lvl(tr + 31, 1, 0, 0, 3'd0, 0);
    idle(2);
    rst = 1'b0;
    lvl(tr + 38, 1, 0, 0, 3'd0, 0);
    lvl(tr + 39, 1, 0, 1, 3'd0, 0);
    idle(10);
    btn_item = 1'b0;
    btn_up = 1'b0;
    idle(10);

    // Up in RUN ignored
    tq = cyc;
    btn_up = 1'b1;
    idle(10);
    btn_up = 1'b0;
    idle(10);

    // Enter SET with up already held: no repeat
    tq = cyc;
    btn_up = 1'b1;
    idle(10);
    btn_mode = 1'b1;
    s = cyc + 7;
    lvl(s, 0, 1, 1, 3'd3, 0);
    lvl(s + 10, 0, 1, 1, 3'd3, 0);
    idle(10);
    btn_mode = 1'b0;
    idle(30);
    btn_up = 1'b0;
    idle(10);

    // Back to RUN: item_sel and view_dmy kept
    tm = cyc;
    btn_mode = 1'b1;
    lvl(tm + 7, 1, 0, 1, 3'd3, 0);
    idle(10);
    btn_mode = 1'b0;
    idle(10);

    // Idle in SET: timeout or stay
    t = cyc;
    btn_mode = 1'b1;
    s3 = t + 7;
    lvl(s3, 0, 1, 1, 3'd3, 0);
    idle(10);
    btn_mode = 1'b0;
`ifdef SET_TIMEOUT_EN
    lvl(s3 + TO, 0, 1, 1, 3'd3, 0);
    lvl(s3 + TO + 1, 1, 0, 1, 3'd3, 0);
    wait_until(s3 + TO + 10);
`else
    lvl(s3 + 1000, 0, 1, 1, 3'd3, 1);
    wait_until(s3 + 1005);
`endif

    idle(3);
    done = 1'b1;
    idle(3);
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
